// File: rtl/display_tx_sched_if.sv
// CPU-side write/clear requests and display-side strobes of the display TX scheduler.
interface display_tx_sched_if;
    logic       enable;
    logic       cpu_wr;
    logic [7:0] cpu_din;
    logic       clr_req;
    logic [7:0] dsp_status;
    logic       busy;
    logic       ovf;
    logic       disp_address;
    logic       disp_enable;
    logic       disp_w_en;
    logic [7:0] disp_din;
    logic       disp_clr_screen;

    modport master (
        output enable, cpu_wr, cpu_din, clr_req,
        input  dsp_status, busy, ovf, disp_address, disp_enable, disp_w_en,
               disp_din, disp_clr_screen
    );

    modport slave (
        input  enable, cpu_wr, cpu_din, clr_req,
        output dsp_status, busy, ovf, disp_address, disp_enable, disp_w_en,
               disp_din, disp_clr_screen
    );
endinterface

// File: rtl/display_tx_sched.sv
// Buffers CPU display writes in a FIFO, paces them out one char per gap, and runs clear sweeps.
// Optional DISPLAY_TX_UPCASE_EN folds lowercase bytes to uppercase before they are queued.
module display_tx_sched #(
    parameter int DEPTH      = 4,
    parameter int CHAR_GAP   = 116667,
    parameter int CLR_CYCLES = 119928
) (
    input  logic              clk,
    input  logic              rst,
    display_tx_sched_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int TMR_MAX = (CLR_CYCLES > CHAR_GAP) ? CLR_CYCLES : CHAR_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STROBE, GAP, CLEAR} state_t;

    function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef DISPLAY_TX_UPCASE_EN
        if (b[6:0] >= 7'h61 && b[6:0] <= 7'h7A) return b & 8'hDF;
`endif
        return b;
    endfunction

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             wr_req_p0;
    logic             wr_req_p1;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic             clr_go;
    logic             clr_enter;
    logic             clr_pend;
    logic             ovf;
    logic [TMR_W-1:0] tmr;
    state_t           state;
    logic             strobe;
    logic             addr;
    logic             clr_scr;
    logic [7:0]       din;

    // Write strobe edge detect against the registered request
    assign wr_req_p0 = bus.enable & bus.cpu_wr;
    assign push      = wr_req_p0 & ~wr_req_p1;
    assign clr_go    = bus.clr_req | clr_pend;
    assign clr_enter = (state == IDLE) && clr_go;
    assign pop       = (state == IDLE) && !clr_go && (count != '0);
    // The flush on clear entry frees space, so a same-edge write is always kept
    assign push_ok   = push && ((count != FULL) || pop || clr_enter);

    assign bus.busy            = (count == FULL);
    assign bus.dsp_status      = {bus.busy, 7'b0};
    assign bus.ovf             = ovf;
    assign bus.disp_address    = addr;
    assign bus.disp_enable     = strobe;
    assign bus.disp_w_en       = strobe;
    assign bus.disp_din        = din;
    assign bus.disp_clr_screen = clr_scr;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= fold_case(bus.cpu_din);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_req_p1 <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            wr_req_p1 <= wr_req_p0;
            if (push && !push_ok) ovf <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (clr_enter) begin
                rd_ptr <= wr_ptr;
                count  <= (PTR_W + 1)'(push_ok);
            end else begin
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            clr_pend <= 1'b0;
            strobe   <= 1'b0;
            addr     <= 1'b1;
            clr_scr  <= 1'b0;
            din      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_go) begin
                        state    <= CLEAR;
                        clr_pend <= 1'b0;
                        tmr      <= TMR_W'(CLR_CYCLES - 1);
                        clr_scr  <= 1'b1;
                    end else if (pop) begin
                        state  <= STROBE;
                        din    <= mem[rd_ptr];
                        strobe <= 1'b1;
                        addr   <= 1'b0;
                    end
                end
                // The IDLE cycle after GAP is the last idle cycle of the char gap
                STROBE: begin
                    strobe   <= 1'b0;
                    addr     <= 1'b1;
                    clr_pend <= clr_pend | bus.clr_req;
                    if (CHAR_GAP > 1) begin
                        state <= GAP;
                        tmr   <= TMR_W'((CHAR_GAP > 1) ? CHAR_GAP - 2 : 0);
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    clr_pend <= clr_pend | bus.clr_req;
                    if (tmr == '0) state <= IDLE;
                    else tmr <= tmr - TMR_W'(1);
                end
                CLEAR: begin
                    if (tmr == '0) begin
                        state   <= IDLE;
                        clr_scr <= 1'b0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_tx_sched.sv
// Randomized and directed bench for display_tx_sched against an edge-timed queue model.
module tb_display_tx_sched;
    localparam int DEPTH      = 4;
    localparam int CHAR_GAP   = 4;
    localparam int CLR_CYCLES = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    display_tx_sched_if bus();

    display_tx_sched #(
        .DEPTH(DEPTH),
        .CHAR_GAP(CHAR_GAP),
        .CLR_CYCLES(CLR_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_clr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the scheduler is free to decide at edge m_next; a decision
    // either starts a clear sweep or emits the queue head.
    logic [7:0] m_q[$];
    int         m_e;
    int         m_next;
    int         m_clr_last;
    bit         m_pend;
    bit         m_req_prev;
    bit         m_strobe;
    bit         m_ovf;
    bit         m_clr;
    logic [7:0] m_last;

    function automatic logic [7:0] ref_case(input logic [7:0] b);
`ifdef DISPLAY_TX_UPCASE_EN
        if ((b % 128) >= 97 && (b % 128) <= 122) return b - 8'd32;
`endif
        return b;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_e        = 0;
        m_next     = 0;
        m_clr_last = -10;
        m_pend     = 1'b0;
        m_req_prev = 1'b0;
        m_strobe   = 1'b0;
        m_ovf      = 1'b0;
        m_clr      = 1'b0;
        m_last     = 8'h00;
    endtask

    task automatic model_edge(input bit req, input logic [7:0] d, input bit clr);
        bit push;
        push       = req && !m_req_prev;
        m_req_prev = req;
        m_strobe   = 1'b0;
        if (m_e >= m_next) begin
            if (clr || m_pend) begin
                m_pend = 1'b0;
                m_q.delete();
                m_clr_last = m_e + CLR_CYCLES - 1;
                m_next     = m_e + CLR_CYCLES + 1;
            end else if (m_q.size() > 0) begin
                m_last   = m_q.pop_front();
                m_strobe = 1'b1;
                m_next   = m_e + CHAR_GAP + 1;
            end
        end else if (m_e > m_clr_last + 1) begin
            m_pend = m_pend | clr;
        end
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ref_case(d));
            else m_ovf = 1'b1;
        end
        m_clr = (m_e <= m_clr_last);
        m_e++;
    endtask

    task automatic compare_all();
        bit full;
        full = (m_q.size() == DEPTH);
        chk("disp_enable", bus.disp_enable, m_strobe);
        chk("disp_w_en", bus.disp_w_en, m_strobe);
        chk("disp_address", bus.disp_address, !m_strobe);
        chk("disp_din", bus.disp_din, m_last);
        chk("disp_clr_screen", bus.disp_clr_screen, m_clr);
        chk("busy", bus.busy, full);
        chk("dsp_status", bus.dsp_status, {full, 7'b0});
        chk("ovf", bus.ovf, m_ovf);
        n_strobe += int'(bus.disp_w_en);
        n_clr    += int'(bus.disp_clr_screen);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_enable"}, bus.disp_enable, 1'b0);
        chk({tag, "_w_en"}, bus.disp_w_en, 1'b0);
        chk({tag, "_address"}, bus.disp_address, 1'b1);
        chk({tag, "_din"}, bus.disp_din, 8'h00);
        chk({tag, "_clr"}, bus.disp_clr_screen, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_status"}, bus.dsp_status, 8'h00);
        chk({tag, "_ovf"}, bus.ovf, 1'b0);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic step(input bit en, input bit wr, input logic [7:0] d, input bit clr);
        bus.enable  = en;
        bus.cpu_wr  = wr;
        bus.cpu_din = d;
        bus.clr_req = clr;
        @(posedge clk);
        model_edge(en & wr, d, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic write_once(input logic [7:0] d);
        step(1'b1, 1'b1, d, 1'b0);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic mid_reset();
        bus.enable  = 1'b0;
        bus.cpu_wr  = 1'b0;
        bus.cpu_din = 8'h00;
        bus.clr_req = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset("mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] up_exp;
        bus.enable  = 1'b0;
        bus.cpu_wr  = 1'b0;
        bus.cpu_din = 8'h00;
        bus.clr_req = 1'b0;
        model_reset();
        #3 rst = 1'b1;
        #1 chk_reset("rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        n_strobe = 0;
        write_once(8'hC1);
        idle(8);
        chk("single_write_strobes", n_strobe, 1);

        n_strobe = 0;
        step(1'b1, 1'b1, 8'hC2, 1'b0);
        step(1'b1, 1'b1, 8'hC2, 1'b0);
        step(1'b1, 1'b1, 8'hC2, 1'b0);
        step(1'b0, 1'b0, 8'hC2, 1'b0);
        idle(8);
        chk("held_write_strobes", n_strobe, 1);

        for (int i = 0; i < 10; i++) write_once(8'hD0 + 8'(i));
        chk("burst_ovf", bus.ovf, 1'b1);
        chk("burst_status", bus.dsp_status, 8'h80);
        idle(30);

        write_once(8'hA1);
        write_once(8'hA2);
        write_once(8'hA3);
        n_strobe = 0;
        n_clr = 0;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        write_once(8'hA4);
        idle(20);
        chk("clear_length", n_clr, CLR_CYCLES);
        chk("after_clear_strobes", n_strobe, 1);

        write_once(8'hB1);
        write_once(8'hB2);
        n_strobe = 0;
        n_clr = 0;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(20);
        chk("gap_clear_length", n_clr, CLR_CYCLES);
        chk("gap_clear_strobes", n_strobe, 0);

`ifdef DISPLAY_TX_UPCASE_EN
        up_exp = 8'h41;
`else
        up_exp = 8'h61;
`endif
        write_once(8'h61);
        idle(6);
        chk("lowercase_din", bus.disp_din, up_exp);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 8'($urandom), $urandom_range(0, 150) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_tx_sched.md
Name: display_tx_sched

Overview:
- Sits between the CPU/PIA write path and the character display datapath.
- Buffers characters the CPU writes to the display TX register in a small FIFO.
- Paces those characters to the display with its one-shot write handshake: strobe high, then both strobes low to re-arm.
- Sequences full-frame clear-screen sweeps and reports the Apple-1 style busy flag (DSP bit 7) back to the CPU.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CHAR_GAP, 116667, idle cycles after each strobe (one char per frame at 7 MHz); minimum 1.
- CLR_CYCLES, 119928, cycles clr_screen is held; one full 456x263 frame.

Ports:
- clk  in  1  7 MHz clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  CPU clock-enable strobe.
- cpu_wr  in  1  CPU write to DSP register.
- cpu_din  in  8  CPU write data.
- clr_req  in  1  clear-screen request; level or pulse.
- dsp_status  out  8  CPU read value: {busy, 7'b0}.
- busy  out  1  FIFO full.
- ovf  out  1  sticky overflow flag.
- disp_address  out  1  display register select: 0 = TX, 1 = idle/scroll-clear.
- disp_enable  out  1  display enable strobe.
- disp_w_en  out  1  display write strobe.
- disp_din  out  8  display data.
- disp_clr_screen  out  1  display clear command.

Behaviour:
- Reset values:
  - All outputs 0, except disp_address = 1.
  - FIFO empty, state IDLE, counters 0.
- Write acceptance:
  - A write is accepted on the first cycle that (enable & cpu_wr) is high after a cycle where it was low. This is rising-edge detection on a registered copy.
  - An accepted write pushes cpu_din into the FIFO at that clock edge.
  - A write while full is dropped and sets ovf. ovf clears only on reset.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers and a (log2(DEPTH)+1)-bit count.
  - Pointers wrap DEPTH-1 -> 0.
  - Simultaneous push and pop: both occur, count unchanged. This is legal even when full, because the pop frees a slot in the same edge.
  - busy = (count == DEPTH), registered-free (combinational from count). dsp_status[7] = busy.
- States: IDLE, STROBE, GAP, CLEAR.
  - IDLE:
    - clr_req high -> CLEAR. Clear has priority over pending characters.
    - Else FIFO non-empty -> STROBE. Pop the head into the disp_din register at the same edge.
  - STROBE (1 cycle): disp_address = 0, disp_enable = 1, disp_w_en = 1. Next state GAP.
  - GAP:
    - disp_enable = 0, disp_w_en = 0, disp_address = 1.
    - Count CHAR_GAP cycles, then go to IDLE.
    - clr_req during GAP is latched as pending and taken at IDLE.
  - CLEAR:
    - On entry, flush the FIFO (count = 0, rd_ptr = wr_ptr) and load the counter.
    - Hold disp_clr_screen = 1 for exactly CLR_CYCLES cycles, then go to IDLE.
    - Writes accepted during CLEAR are kept and emitted afterwards.
    - clr_req during CLEAR is ignored and not re-latched.
- Latency: a char pushed at edge k gives its strobe cycle starting at edge k+1, if IDLE and no clear is pending.
- Throughput: one char per CHAR_GAP+1 cycles.
- disp_din holds the last emitted char between strobes.
- Reset mid-operation aborts all strobes and clears immediately: outputs return to their reset values asynchronously.

Optional Feature:
- Macro: DISPLAY_TX_UPCASE_EN.
- Defined: bytes 0x61..0x7A (and 0xE1..0xFA) have bit 5 cleared before being pushed, i.e. lowercase is folded to uppercase.
- Undefined: bytes are pushed unmodified.
- All other bytes are unaffected in both cases.

Test Plan:
- DEPTH=4, CHAR_GAP=4, CLR_CYCLES=10. Write 0xC1 once -> one strobe cycle with disp_din=0xC1 and disp_address=0, one edge after the push; next strobe no earlier than 5 cycles later.
- Hold enable&cpu_wr high for 3 cycles with 0xC2 -> exactly one push, exactly one strobe.
- Write 5 chars back-to-back while the first is in GAP -> busy=1 after the 4th queued, 5th dropped, ovf=1, dsp_status=0x80; the 4 queued chars are emitted in order.
- Pulse clr_req with 2 chars queued -> FIFO flushed, disp_clr_screen high for exactly 10 cycles, no strobes; a write during CLEAR is emitted after.
- Pulse clr_req during GAP -> CLEAR entered at the next IDLE, before the queued char.
- With DISPLAY_TX_UPCASE_EN, write 0x61 -> disp_din=0x41; without the macro -> disp_din=0x61.
